// File: rtl/msm_batch_sched_if.sv
// Handshake bundle between the MSM batch scheduler and its host, DRAM loader,
// point-memory controller and bucket unit.
interface msm_batch_sched_if #(
   parameter int unsigned BATCH_W = 16,
   parameter int unsigned WIN_W   = 7
);
   logic               job_start;
   logic [BATCH_W-1:0] cfg_num_batch;
   logic               dram_load_req;
   logic               dram_load_ack;
   logic               load_done;
   logic               load_bank;
   logic               msm_start;
   logic               msm_done;
   logic               bank_sel;
   logic               win_done;
   logic [WIN_W-1:0]   win_idx;
   logic [BATCH_W-1:0] batch_idx;
   logic               job_busy;
   logic               job_done;
   logic               err;

   modport master (
      input  job_start, cfg_num_batch, dram_load_ack, load_done, win_done,
      output dram_load_req, load_bank, msm_start, msm_done, bank_sel,
             win_idx, batch_idx, job_busy, job_done, err
   );

   modport slave (
      output job_start, cfg_num_batch, dram_load_ack, load_done, win_done,
      input  dram_load_req, load_bank, msm_start, msm_done, bank_sel,
             win_idx, batch_idx, job_busy, job_done, err
   );
endinterface

// File: rtl/msm_batch_sched.sv
// MSM job sequencer: batches points, walks every scalar window per batch and
// ping-pongs two bank groups. MSM_BATCH_SCHED_PERF_EN adds stall/busy counters.
module msm_batch_sched #(
   parameter int unsigned P_NUM    = 16,
   parameter int unsigned WIDTH_ID = 2,
   parameter int unsigned NUM_WIN  = 256 / WIDTH_ID,
   parameter int unsigned BATCH_W  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   msm_batch_sched_if.master  bus
`ifdef MSM_BATCH_SCHED_PERF_EN
   ,
   output logic [31:0]        stall_cnt,
   output logic [31:0]        busy_cnt
`endif
);

   localparam int unsigned WIN_W = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

   if (NUM_WIN < 2 || P_NUM == 0 || WIDTH_ID == 0) begin : g_cfg_chk
      $error("msm_batch_sched: unsupported parameter set");
   end

   typedef enum logic [1:0] {L_IDLE, L_REQ, L_WAIT} l_state_e;
   typedef enum logic [1:0] {C_IDLE, C_WAITBANK, C_RUN, C_DONE} c_state_e;

   l_state_e           l_state;
   c_state_e           c_state;
   logic               req_q;
   logic               load_bank_q;
   logic [BATCH_W-1:0] loads_q;
   logic [BATCH_W-1:0] num_batch_q;
   logic [BATCH_W-1:0] batch_q;
   logic [WIN_W-1:0]   win_q;
   logic               bank_sel_q;
   logic               msm_start_q;
   logic               msm_done_q;
   logic               job_busy_q;
   logic               job_done_q;
   logic               err_q;
   logic [1:0]         bank_full_q;

   logic               start_c;
   logic               zero_job_c;
   logic               tgt_c;
   logic               load_set_c;
   logic               last_win_c;
   logic               run_clr_c;
   logic               bank_ready_c;
   logic               err_c;
   logic [1:0]         bank_full_c;

   // Shared decode; bank_ready_c bypasses a same-cycle load_done into compute
   always_comb begin
      start_c      = bus.job_start && (c_state == C_IDLE) && (bus.cfg_num_batch != '0);
      zero_job_c   = bus.job_start && (c_state == C_IDLE) && (bus.cfg_num_batch == '0);
      tgt_c        = ~bank_sel_q;
      load_set_c   = (l_state == L_WAIT) && bus.load_done;
      last_win_c   = (win_q == WIN_W'(NUM_WIN - 1));
      run_clr_c    = (c_state == C_RUN) && bus.win_done && last_win_c;
      bank_ready_c = bank_full_q[bank_sel_q] || (load_set_c && (load_bank_q == bank_sel_q));
      err_c        = (bus.job_start && job_busy_q)
                   || (bus.win_done && (c_state != C_RUN))
                   || (bus.load_done && (l_state != L_WAIT))
                   || (bus.dram_load_ack && (l_state != L_REQ))
                   || (run_clr_c && load_set_c && (load_bank_q == bank_sel_q));
   end

   // Bank occupancy: compute release is applied first so a colliding fill wins
   always_comb begin
      bank_full_c = bank_full_q;
      if (run_clr_c) begin
         bank_full_c[bank_sel_q] = 1'b0;
      end
      if (load_set_c) begin
         bank_full_c[load_bank_q] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_full_q <= '0;
         err_q       <= 1'b0;
      end else begin
         bank_full_q <= bank_full_c;
         if (err_c) begin
            err_q <= 1'b1;
         end
      end
   end

   // Load FSM: one outstanding DRAM batch load at a time
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l_state     <= L_IDLE;
         req_q       <= 1'b0;
         load_bank_q <= 1'b0;
         loads_q     <= '0;
      end else begin
         case (l_state)
            L_IDLE: begin
               if (start_c) begin
                  l_state     <= L_REQ;
                  req_q       <= 1'b1;
                  load_bank_q <= 1'b0;
                  loads_q     <= '0;
               end else if (job_busy_q && (loads_q < num_batch_q) && !bank_full_q[tgt_c]) begin
                  l_state     <= L_REQ;
                  req_q       <= 1'b1;
                  load_bank_q <= tgt_c;
               end
            end
            L_REQ: begin
               if (bus.dram_load_ack) begin
                  l_state <= L_WAIT;
                  req_q   <= 1'b0;
               end
            end
            L_WAIT: begin
               if (bus.load_done) begin
                  l_state <= L_IDLE;
                  loads_q <= loads_q + BATCH_W'(1);
               end
            end
            default: begin
               l_state <= L_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   // Compute FSM: batch/window sequencing toward the memory controller
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_state     <= C_IDLE;
         num_batch_q <= '0;
         batch_q     <= '0;
         win_q       <= '0;
         bank_sel_q  <= 1'b0;
         msm_start_q <= 1'b0;
         msm_done_q  <= 1'b0;
         job_busy_q  <= 1'b0;
         job_done_q  <= 1'b0;
      end else begin
         msm_start_q <= 1'b0;
         msm_done_q  <= 1'b0;
         job_done_q  <= 1'b0;
         case (c_state)
            C_IDLE: begin
               if (start_c) begin
                  c_state     <= C_WAITBANK;
                  num_batch_q <= bus.cfg_num_batch;
                  batch_q     <= '0;
                  win_q       <= '0;
                  bank_sel_q  <= 1'b0;
                  job_busy_q  <= 1'b1;
               end else if (zero_job_c) begin
                  c_state    <= C_DONE;
                  job_done_q <= 1'b1;
               end
            end
            C_WAITBANK: begin
               if (bank_ready_c) begin
                  c_state     <= C_RUN;
                  msm_start_q <= 1'b1;
                  win_q       <= '0;
               end
            end
            C_RUN: begin
               if (bus.win_done) begin
                  if (!last_win_c) begin
                     msm_done_q <= 1'b1;
                     win_q      <= win_q + WIN_W'(1);
                  end else begin
                     bank_sel_q <= ~bank_sel_q;
                     batch_q    <= batch_q + BATCH_W'(1);
                     win_q      <= '0;
                     if ((batch_q + BATCH_W'(1)) == num_batch_q) begin
                        c_state    <= C_DONE;
                        job_done_q <= 1'b1;
                        job_busy_q <= 1'b0;
                     end else begin
                        c_state <= C_WAITBANK;
                     end
                  end
               end
            end
            C_DONE: begin
               c_state <= C_IDLE;
            end
            default: begin
               c_state <= C_IDLE;
            end
         endcase
      end
   end

`ifdef MSM_BATCH_SCHED_PERF_EN
   // Saturating performance counters, cleared by an accepted job_start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         busy_cnt  <= '0;
      end else if (bus.job_start && (c_state == C_IDLE)) begin
         stall_cnt <= '0;
         busy_cnt  <= '0;
      end else begin
         if ((c_state == C_WAITBANK) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'(1);
         end
         if (job_busy_q && (busy_cnt != '1)) begin
            busy_cnt <= busy_cnt + 32'(1);
         end
      end
   end
`endif

   assign bus.dram_load_req = req_q;
   assign bus.load_bank     = load_bank_q;
   assign bus.msm_start     = msm_start_q;
   assign bus.msm_done      = msm_done_q;
   assign bus.bank_sel      = bank_sel_q;
   assign bus.win_idx       = win_q;
   assign bus.batch_idx     = batch_q;
   assign bus.job_busy      = job_busy_q;
   assign bus.job_done      = job_done_q;
   assign bus.err           = err_q;

endmodule

// File: tb/tb_msm_batch_sched.sv
// Directed bench for msm_batch_sched: single/multi batch, slow DRAM, empty job,
// protocol errors and mid-job reset.
module tb_msm_batch_sched;

   localparam int unsigned BATCH_W = 16;
   localparam int unsigned WIN_W   = 7;
   localparam int unsigned NWIN    = 128;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   int   req_cnt;
   int   start_cnt;
   int   done_cnt;
   int   jdone_cnt;
   logic req_prev;

   msm_batch_sched_if #(.BATCH_W(BATCH_W), .WIN_W(WIN_W)) bus ();

`ifdef MSM_BATCH_SCHED_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] busy_cnt;
   msm_batch_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                        .stall_cnt(stall_cnt), .busy_cnt(busy_cnt));
`else
   msm_batch_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
      $fatal(1, "watchdog");
   end

   // Pulse counters sampled on the inactive edge
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_prev <= 1'b0;
      end else begin
         req_prev <= bus.dram_load_req;
         if (bus.dram_load_req && !req_prev) req_cnt <= req_cnt + 1;
         if (bus.msm_start) start_cnt <= start_cnt + 1;
         if (bus.msm_done)  done_cnt  <= done_cnt + 1;
         if (bus.job_done)  jdone_cnt <= jdone_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic start_job(input int n);
      bus.cfg_num_batch = BATCH_W'(n);
      bus.job_start     = 1'b1;
      tick();
      bus.job_start     = 1'b0;
      bus.cfg_num_batch = '0;
   endtask

   task automatic wait_req();
      for (int i = 0; i < 20 && !bus.dram_load_req; i++) tick();
      check("req_seen", 32'(bus.dram_load_req), 1);
   endtask

   // Ack after ack_wait cycles, load_done done_wait cycles after the ack cycle + 1
   task automatic serve_load(input int ack_wait, input int done_wait);
      wait_req();
      repeat (ack_wait) tick();
      bus.dram_load_ack = 1'b1;
      tick();
      bus.dram_load_ack = 1'b0;
      check("req_drop", 32'(bus.dram_load_req), 0);
      repeat (done_wait) tick();
      bus.load_done = 1'b1;
      tick();
      bus.load_done = 1'b0;
   endtask

   task automatic run_windows(input int n);
      for (int i = 0; i < n; i++) begin
         bus.win_done = 1'b1;
         tick();
         bus.win_done = 1'b0;
         tick();
      end
   endtask

   // Returns one cycle after the final win_done of the batch
   task automatic run_batch();
      int base;
      base = done_cnt;
      run_windows(NWIN - 1);
      check("win_idx_last", 32'(bus.win_idx), NWIN - 1);
      bus.win_done = 1'b1;
      tick();
      bus.win_done = 1'b0;
      check("msm_done_per_batch", 32'(done_cnt - base), NWIN - 1);
   endtask

   int b_req;
   int b_start;
   int b_done;
   int b_jd;

   initial begin
      n_checks = 0; n_errors = 0;
      req_cnt = 0; start_cnt = 0; done_cnt = 0; jdone_cnt = 0;
      rst_n = 1'b0;
      bus.job_start = 1'b0; bus.cfg_num_batch = '0;
      bus.dram_load_ack = 1'b0; bus.load_done = 1'b0; bus.win_done = 1'b0;
      tick();
      check("rst_req", 32'(bus.dram_load_req), 0);
      check("rst_busy", 32'(bus.job_busy), 0);
      check("rst_win_idx", 32'(bus.win_idx), 0);
      check("rst_batch_idx", 32'(bus.batch_idx), 0);
      check("rst_err", 32'(bus.err), 0);
      rst_n = 1'b1;
      tick();

      // Single batch
      b_req = req_cnt; b_start = start_cnt;
      start_job(1);
      check("t1_busy", 32'(bus.job_busy), 1);
      check("t1_req", 32'(bus.dram_load_req), 1);
      check("t1_load_bank", 32'(bus.load_bank), 0);
      serve_load(3, 15);
      check("t1_no_early_start", 32'(start_cnt - b_start), 0);
      check("t1_msm_start", 32'(bus.msm_start), 1);
      check("t1_bank_sel0", 32'(bus.bank_sel), 0);
      run_batch();
      check("t1_job_done", 32'(bus.job_done), 1);
      check("t1_busy_low", 32'(bus.job_busy), 0);
      check("t1_bank_sel_end", 32'(bus.bank_sel), 1);
      check("t1_load_bank_end", 32'(bus.load_bank), 0);
      tick();
      check("t1_job_done_pulse", 32'(bus.job_done), 0);
      check("t1_req_count", 32'(req_cnt - b_req), 1);
      check("t1_err", 32'(bus.err), 0);

      // Three batches, fast loads
      b_req = req_cnt; b_start = start_cnt; b_done = done_cnt;
      start_job(3);
      serve_load(0, 1);
      check("t2_start0", 32'(bus.msm_start), 1);
      check("t2_batch0", 32'(bus.batch_idx), 0);
      wait_req();
      check("t2_load1_bank", 32'(bus.load_bank), 1);
      check("t2_load1_sel", 32'(bus.bank_sel), 0);
      serve_load(0, 1);
      run_batch();
      check("t2_gap_no_start", 32'(bus.msm_start), 0);
      check("t2_sel_toggle", 32'(bus.bank_sel), 1);
      tick();
      check("t2_start1_at_2", 32'(bus.msm_start), 1);
      check("t2_batch1", 32'(bus.batch_idx), 1);
      check("t2_load2_bank", 32'(bus.load_bank), 0);
      serve_load(0, 1);
      run_batch();
      tick();
      check("t2_start2_at_2", 32'(bus.msm_start), 1);
      check("t2_batch2", 32'(bus.batch_idx), 2);
      check("t2_sel2", 32'(bus.bank_sel), 0);
      run_batch();
      check("t2_job_done", 32'(bus.job_done), 1);
      check("t2_batch_end", 32'(bus.batch_idx), 3);
      check("t2_req_count", 32'(req_cnt - b_req), 3);
      check("t2_start_count", 32'(start_cnt - b_start), 3);
      check("t2_done_count", 32'(done_cnt - b_done), 3 * (NWIN - 1));
      check("t2_err", 32'(bus.err), 0);
      tick();

      // Slow DRAM: batch 1 load completes 50 cycles after batch 0 ends
      start_job(2);
      serve_load(0, 1);
      wait_req();
      bus.dram_load_ack = 1'b1;
      tick();
      bus.dram_load_ack = 1'b0;
      run_batch();
      b_start = start_cnt;
      repeat (49) tick();
      check("t3_stall_no_start", 32'(start_cnt - b_start), 0);
      check("t3_stall_now", 32'(bus.msm_start), 0);
      bus.load_done = 1'b1;
      tick();
      bus.load_done = 1'b0;
      check("t3_start_after_load", 32'(bus.msm_start), 1);
      check("t3_batch1", 32'(bus.batch_idx), 1);
      run_batch();
      check("t3_job_done", 32'(bus.job_done), 1);
      check("t3_err", 32'(bus.err), 0);
      tick();

      // Empty job
      b_req = req_cnt;
      start_job(0);
      check("t4_job_done", 32'(bus.job_done), 1);
      check("t4_busy", 32'(bus.job_busy), 0);
      tick();
      check("t4_pulse_end", 32'(bus.job_done), 0);
      check("t4_req_never", 32'(req_cnt - b_req), 0);
      check("t4_err", 32'(bus.err), 0);

      // job_start while busy
      do_reset();
      start_job(1);
      bus.cfg_num_batch = BATCH_W'(5);
      bus.job_start = 1'b1;
      tick();
      bus.job_start = 1'b0;
      bus.cfg_num_batch = '0;
      check("t5_err_busy_start", 32'(bus.err), 1);
      check("t5_still_busy", 32'(bus.job_busy), 1);
      serve_load(0, 1);
      check("t5_start", 32'(bus.msm_start), 1);
      run_batch();
      check("t5_done_one_batch", 32'(bus.job_done), 1);
      check("t5_batch_end", 32'(bus.batch_idx), 1);

      // win_done while waiting for a bank
      do_reset();
      check("t6_err_cleared", 32'(bus.err), 0);
      start_job(1);
      bus.win_done = 1'b1;
      tick();
      bus.win_done = 1'b0;
      check("t6_err_win", 32'(bus.err), 1);
      check("t6_win_idx", 32'(bus.win_idx), 0);
      check("t6_no_done", 32'(bus.msm_done), 0);

      // load_done with no load outstanding
      do_reset();
      bus.load_done = 1'b1;
      tick();
      bus.load_done = 1'b0;
      check("t7_err_load", 32'(bus.err), 1);
      check("t7_idle", 32'(bus.job_busy), 0);

      // Asynchronous reset mid-run, then a fresh job
      do_reset();
      start_job(1);
      serve_load(0, 1);
      run_windows(40);
      check("t8_win40", 32'(bus.win_idx), 40);
      b_jd = jdone_cnt;
      #2;
      rst_n = 1'b0;
      #1;
      check("t8_async_win", 32'(bus.win_idx), 0);
      check("t8_async_busy", 32'(bus.job_busy), 0);
      check("t8_async_sel", 32'(bus.bank_sel), 0);
      check("t8_async_req", 32'(bus.dram_load_req), 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("t8_no_job_done", 32'(jdone_cnt - b_jd), 0);
      b_done = done_cnt;
      start_job(1);
      check("t8_req", 32'(bus.dram_load_req), 1);
      check("t8_load_bank", 32'(bus.load_bank), 0);
      serve_load(1, 2);
      check("t8_start", 32'(bus.msm_start), 1);
      run_batch();
      check("t8_job_done", 32'(bus.job_done), 1);
      check("t8_done_total", 32'(done_cnt - b_done), NWIN - 1);
      check("t8_err", 32'(bus.err), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
